// File: rtl/fofb_pkg.sv
// fofb_pkg: shared state type, status code and us-divider helper for the FOFB cell tracker.
package fofb_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, VALID, TIMEOUT} fofbState_e;
  localparam logic [1:0] ST_SUCCESS = 2'd0;
  function automatic int usDivider(input int sysClkRate);
    return sysClkRate / 1000000 - 1;
  endfunction
endpackage

// File: rtl/fofb_cell_tracker_if.sv
// fofb_cell_tracker_if: per-link cell status strobes arriving from the link CDC.
interface fofb_cell_tracker_if #(
  parameter int NUM_LINKS = 2,
  parameter int CELL_INDEX_WIDTH = 5
);
  logic [NUM_LINKS-1:0] statusValid;
  logic [2*NUM_LINKS-1:0] statusCode;
  logic [NUM_LINKS*CELL_INDEX_WIDTH-1:0] statusCellIndex;
  logic [NUM_LINKS-1:0] statusFOFBenabled;
  modport master(output statusValid, statusCode, statusCellIndex, statusFOFBenabled);
  modport slave(input statusValid, statusCode, statusCellIndex, statusFOFBenabled);
endinterface

// File: rtl/fofb_link_merge.sv
// fofb_link_merge: OR-merges all link status strobes into one-hot accept/enabled cell masks.
module fofb_link_merge
  import fofb_pkg::*;
#(
  parameter int MAX_CELLS = 32,
  parameter int NUM_LINKS = 2,
  parameter int CELL_INDEX_WIDTH = $clog2(MAX_CELLS)
) (
  input  logic [NUM_LINKS-1:0] statusValid,
  input  logic [2*NUM_LINKS-1:0] statusCode,
  input  logic [NUM_LINKS*CELL_INDEX_WIDTH-1:0] statusCellIndex,
  input  logic [NUM_LINKS-1:0] statusFOFBenabled,
  output logic [MAX_CELLS-1:0] acceptMask,
  output logic [MAX_CELLS-1:0] enabledMask
);
  localparam int SPAN = 2 ** CELL_INDEX_WIDTH;
  logic [SPAN-1:0] hot;
  // Indices at or above MAX_CELLS land in the discarded upper bits of hot
  always_comb begin
    acceptMask = '0;
    enabledMask = '0;
    hot = '0;
    for (int k = 0; k < NUM_LINKS; k++) begin
      hot = statusValid[k] && statusCode[2*k +: 2] == ST_SUCCESS
          ? SPAN'(1) << statusCellIndex[k*CELL_INDEX_WIDTH +: CELL_INDEX_WIDTH] : '0;
      acceptMask |= hot[MAX_CELLS-1:0];
      enabledMask |= statusFOFBenabled[k] ? hot[MAX_CELLS-1:0] : '0;
    end
  end
endmodule

// File: rtl/fofb_cell_tracker.sv
// fofb_cell_tracker: per-FA-cycle cell arrival tracker with timeout/overrun detection.
// Optional per-cell miss statistics when CELL_MISS_STATS_EN is defined.
module fofb_cell_tracker
  import fofb_pkg::*;
#(
  parameter int SYSCLK_RATE = 100000000,
  parameter int MAX_CELLS = 32,
  parameter int NUM_LINKS = 2,
  parameter int CELL_INDEX_WIDTH = $clog2(MAX_CELLS),
  parameter int TIMER_WIDTH = 8,
  parameter int SEQNO_WIDTH = 3
) (
  input  logic sysClk,
  input  logic sysResetN,
  input  logic FAstrobe,
  input  logic [$clog2(MAX_CELLS+1)-1:0] cellCount,
  input  logic [TIMER_WIDTH-1:0] timeoutUs,
  fofb_cell_tracker_if.slave status,
  output logic readoutActive,
  output logic readoutValid,
  output logic readTimeout,
  output logic fofbEnabled,
  output logic [MAX_CELLS-1:0] fofbBitmapAll,
  output logic [MAX_CELLS-1:0] fofbBitmapEnabled,
  output logic [MAX_CELLS-1:0] bitmapAllSnap,
  output logic [MAX_CELLS-1:0] bitmapEnabledSnap,
  output logic [$clog2(MAX_CELLS+1)-1:0] cellCounter,
  output logic [TIMER_WIDTH-1:0] readoutTime,
  output logic [SEQNO_WIDTH-1:0] seqno,
  output logic timeoutStrobe,
  output logic overrunStrobe
`ifdef CELL_MISS_STATS_EN
  , input logic [CELL_INDEX_WIDTH-1:0] missAddr,
  output logic [7:0] missCount
`endif
);
  localparam int CW = $clog2(MAX_CELLS + 1);
  localparam int DIV_RELOAD = usDivider(SYSCLK_RATE);
  localparam int DW = DIV_RELOAD > 0 ? $clog2(DIV_RELOAD + 1) : 1;
  fofbState_e state;
  logic [MAX_CELLS-1:0] acceptMask, enabledMask, nextAll, nextEnabled;
  logic [CW-1:0] fofbCounter;
  logic [TIMER_WIDTH-1:0] readoutTimer;
  logic [DW-1:0] divider;
  fofb_link_merge #(
    .MAX_CELLS(MAX_CELLS),
    .NUM_LINKS(NUM_LINKS),
    .CELL_INDEX_WIDTH(CELL_INDEX_WIDTH)
  ) linkMerge (
    .statusValid(status.statusValid),
    .statusCode(status.statusCode),
    .statusCellIndex(status.statusCellIndex),
    .statusFOFBenabled(status.statusFOFBenabled),
    .acceptMask(acceptMask),
    .enabledMask(enabledMask)
  );
  assign nextAll = fofbBitmapAll | acceptMask;
  assign nextEnabled = fofbBitmapEnabled | enabledMask;
  // Completion compares the registered counter, so it lands one cycle after the last accept
  always_ff @(posedge sysClk or negedge sysResetN)
    if (!sysResetN) begin
      state <= IDLE;
      readoutActive <= 1'b0;
      readoutValid <= 1'b0;
      readTimeout <= 1'b0;
      fofbEnabled <= 1'b0;
      fofbBitmapAll <= '0;
      fofbBitmapEnabled <= '0;
      bitmapAllSnap <= '0;
      bitmapEnabledSnap <= '0;
      cellCounter <= '0;
      fofbCounter <= '0;
      readoutTimer <= '0;
      divider <= '0;
      readoutTime <= '0;
      seqno <= '0;
      timeoutStrobe <= 1'b0;
      overrunStrobe <= 1'b0;
    end else begin
      timeoutStrobe <= 1'b0;
      overrunStrobe <= 1'b0;
      if (FAstrobe) begin
        bitmapAllSnap <= fofbBitmapAll;
        bitmapEnabledSnap <= fofbBitmapEnabled;
        fofbBitmapAll <= '0;
        fofbBitmapEnabled <= '0;
        cellCounter <= '0;
        fofbCounter <= '0;
        readoutTimer <= '0;
        divider <= DW'(DIV_RELOAD / 2);
        overrunStrobe <= state == ACTIVE;
        state <= ACTIVE;
        readoutActive <= 1'b1;
        readoutValid <= 1'b0;
        readTimeout <= 1'b0;
      end else if (state == ACTIVE) begin
        fofbBitmapAll <= nextAll;
        fofbBitmapEnabled <= nextEnabled;
        cellCounter <= CW'($countones(nextAll));
        fofbCounter <= CW'($countones(nextEnabled));
        divider <= divider == '0 ? DW'(DIV_RELOAD) : divider - 1'b1;
        if (divider == '0 && readoutTimer != '1) readoutTimer <= readoutTimer + 1'b1;
        if (cellCounter == cellCount) begin
          state <= VALID;
          readoutActive <= 1'b0;
          readoutValid <= 1'b1;
          fofbEnabled <= fofbCounter == cellCount;
          seqno <= seqno + 1'b1;
          readoutTime <= readoutTimer;
        end else if (timeoutUs != '0 && readoutTimer >= timeoutUs) begin
          state <= TIMEOUT;
          readoutActive <= 1'b0;
          readTimeout <= 1'b1;
          fofbEnabled <= 1'b0;
          readoutTime <= readoutTimer;
          timeoutStrobe <= 1'b1;
        end
      end
    end
`ifdef CELL_MISS_STATS_EN
  logic [7:0] missCnt [MAX_CELLS];
  always_ff @(posedge sysClk or negedge sysResetN)
    if (!sysResetN) begin
      for (int i = 0; i < MAX_CELLS; i++) missCnt[i] <= '0;
      missCount <= '0;
    end else begin
      for (int i = 0; i < MAX_CELLS; i++)
        if (FAstrobe && !fofbBitmapAll[i] && CW'(i) < cellCount && missCnt[i] != 8'hFF)
          missCnt[i] <= missCnt[i] + 8'd1;
      missCount <= missCnt[missAddr];
    end
`endif
endmodule

// File: tb/tb_fofb_cell_tracker.sv
// tb_fofb_cell_tracker: directed tables, hand sequences and randomized run against a set-based model.
module tb_fofb_cell_tracker;
  localparam int NL = 2, MC = 32, IW = 5, TW = 8, SW = 3;
  logic sysClk = 0, sysResetN = 0, FAstrobe = 0;
  logic [5:0] cellCount = 0;
  logic [TW-1:0] timeoutUs = 0;
  logic readoutActive, readoutValid, readTimeout, fofbEnabled, timeoutStrobe, overrunStrobe;
  logic [MC-1:0] fofbBitmapAll, fofbBitmapEnabled, bitmapAllSnap, bitmapEnabledSnap;
  logic [5:0] cellCounter;
  logic [TW-1:0] readoutTime;
  logic [SW-1:0] seqno;
  fofb_cell_tracker_if #(.NUM_LINKS(NL), .CELL_INDEX_WIDTH(IW)) link ();
`ifdef CELL_MISS_STATS_EN
  logic [IW-1:0] missAddr = 0;
  logic [7:0] missCount;
`endif
  fofb_cell_tracker dut (
    .sysClk(sysClk), .sysResetN(sysResetN), .FAstrobe(FAstrobe), .cellCount(cellCount),
    .timeoutUs(timeoutUs), .status(link), .readoutActive(readoutActive),
    .readoutValid(readoutValid), .readTimeout(readTimeout), .fofbEnabled(fofbEnabled),
    .fofbBitmapAll(fofbBitmapAll), .fofbBitmapEnabled(fofbBitmapEnabled),
    .bitmapAllSnap(bitmapAllSnap), .bitmapEnabledSnap(bitmapEnabledSnap),
    .cellCounter(cellCounter), .readoutTime(readoutTime), .seqno(seqno),
    .timeoutStrobe(timeoutStrobe), .overrunStrobe(overrunStrobe)
`ifdef CELL_MISS_STATS_EN
    , .missAddr(missAddr), .missCount(missCount)
`endif
  );
  always #5 sysClk = ~sysClk;
  int checks = 0, failures = 0;
  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction
  // Reference model: sets of arrived cells plus a phase; timer derived from elapsed cycles
  bit got[MC], gotEn[MC];
  int ph = 0, n = 0, eSeq = 0, eTime = 0;
  bit eFe = 0, eOvr = 0, eTmo = 0;
  logic [MC-1:0] eSnapAll = 0, eSnapEn = 0;
  function automatic logic [MC-1:0] toVec(input bit b[MC]);
    logic [MC-1:0] v = '0;
    for (int i = 0; i < MC; i++) v[i] = b[i];
    return v;
  endfunction
  function automatic int pop(input bit b[MC]);
    int s = 0;
    for (int i = 0; i < MC; i++) s += int'(b[i]);
    return s;
  endfunction
  function automatic int timerAt(input int k);
    int t = k < 50 ? 0 : 1 + (k - 50) / 100;
    return t > 255 ? 255 : t;
  endfunction
  function automatic void modelStep();
    eOvr = 0;
    eTmo = 0;
    if (!sysResetN) begin
      foreach (got[i]) begin got[i] = 0; gotEn[i] = 0; end
      ph = 0; n = 0; eSeq = 0; eTime = 0; eFe = 0; eSnapAll = 0; eSnapEn = 0;
    end else if (FAstrobe) begin
      eSnapAll = toVec(got);
      eSnapEn = toVec(gotEn);
      eOvr = ph == 1;
      foreach (got[i]) begin got[i] = 0; gotEn[i] = 0; end
      n = 0;
      ph = 1;
    end else if (ph == 1) begin
      int have = pop(got);
      int haveEn = pop(gotEn);
      int t = timerAt(n);
      for (int k = 0; k < NL; k++)
        if (link.statusValid[k] && link.statusCode[2*k +: 2] == 2'd0) begin
          int c = int'(link.statusCellIndex[k*IW +: IW]);
          if (c < MC) begin
            got[c] = 1;
            if (link.statusFOFBenabled[k]) gotEn[c] = 1;
          end
        end
      n++;
      if (have == int'(cellCount)) begin
        ph = 2; eSeq = (eSeq + 1) % 8; eTime = t; eFe = haveEn == int'(cellCount);
      end else if (timeoutUs != 0 && t >= int'(timeoutUs)) begin
        ph = 3; eTime = t; eFe = 0; eTmo = 1;
      end
    end
  endfunction
  always @(posedge sysClk) begin
    #1;
    modelStep();
    chk("m.active", 64'(readoutActive), 64'(ph == 1));
    chk("m.valid", 64'(readoutValid), 64'(ph == 2));
    chk("m.timeout", 64'(readTimeout), 64'(ph == 3));
    chk("m.fofbEnabled", 64'(fofbEnabled), 64'(eFe));
    chk("m.bitmapAll", 64'(fofbBitmapAll), 64'(toVec(got)));
    chk("m.bitmapEnabled", 64'(fofbBitmapEnabled), 64'(toVec(gotEn)));
    chk("m.snapAll", 64'(bitmapAllSnap), 64'(eSnapAll));
    chk("m.snapEnabled", 64'(bitmapEnabledSnap), 64'(eSnapEn));
    chk("m.cellCounter", 64'(cellCounter), 64'(pop(got)));
    chk("m.readoutTime", 64'(readoutTime), 64'(eTime));
    chk("m.seqno", 64'(seqno), 64'(eSeq));
    chk("m.timeoutStrobe", 64'(timeoutStrobe), 64'(eTmo));
    chk("m.overrunStrobe", 64'(overrunStrobe), 64'(eOvr));
  end
  task automatic cyc();
    @(posedge sysClk);
    #2;
  endtask
  task automatic setLinks(input logic [1:0] v, input int i0, input int i1, input logic [1:0] en);
    link.statusValid = v;
    link.statusCode = '0;
    link.statusCellIndex = {IW'(i1), IW'(i0)};
    link.statusFOFBenabled = en;
  endtask
  typedef struct {
    logic [5:0] cc; bit fa; logic [1:0] vld; int i0; int i1; logic [1:0] en;
    bit rv; int cnt; logic [MC-1:0] all; logic [MC-1:0] ena; int fe; int seq;
  } vec_t;
  vec_t tbl[$];
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cnt, pulses;
    // cc fa vld i0 i1 en | rv cnt all ena fe(-1 = don't care) seq
    tbl.push_back('{4, 1, 2'b00, 0, 0, 2'b00, 0, 0, 'h0, 'h0, 0, 0});
    tbl.push_back('{4, 0, 2'b00, 0, 0, 2'b00, 0, 0, 'h0, 'h0, 0, 0});
    tbl.push_back('{4, 0, 2'b00, 0, 0, 2'b00, 0, 0, 'h0, 'h0, 0, 0});
    tbl.push_back('{4, 0, 2'b00, 0, 0, 2'b00, 0, 0, 'h0, 'h0, 0, 0});
    tbl.push_back('{4, 0, 2'b11, 0, 1, 2'b11, 0, 2, 'h3, 'h3, 0, 0});
    tbl.push_back('{4, 0, 2'b11, 2, 3, 2'b11, 0, 4, 'hF, 'hF, 0, 0});
    tbl.push_back('{4, 0, 2'b00, 0, 0, 2'b00, 1, 4, 'hF, 'hF, 1, 1});
    tbl.push_back('{4, 0, 2'b00, 0, 0, 2'b00, 1, 4, 'hF, 'hF, 1, 1});
    tbl.push_back('{2, 1, 2'b00, 0, 0, 2'b00, 0, 0, 'h0, 'h0, -1, 1});
    tbl.push_back('{2, 0, 2'b11, 0, 1, 2'b01, 0, 2, 'h3, 'h1, -1, 1});
    tbl.push_back('{2, 0, 2'b00, 0, 0, 2'b00, 1, 2, 'h3, 'h1, 0, 2});
    setLinks(2'b00, 0, 0, 2'b00);
    cyc();
    cyc();
    sysResetN = 1;
    cyc();
    chk("reset.active", 64'(readoutActive), 0);
    chk("reset.valid", 64'(readoutValid), 0);
    chk("reset.seqno", 64'(seqno), 0);
    chk("reset.bitmapAll", 64'(fofbBitmapAll), 0);
    chk("reset.fofbEnabled", 64'(fofbEnabled), 0);
    foreach (tbl[i]) begin
      cellCount = tbl[i].cc;
      FAstrobe = tbl[i].fa;
      setLinks(tbl[i].vld, tbl[i].i0, tbl[i].i1, tbl[i].en);
      cyc();
      chk($sformatf("tbl%0d.readoutValid", i), 64'(readoutValid), 64'(tbl[i].rv));
      chk($sformatf("tbl%0d.cellCounter", i), 64'(cellCounter), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d.bitmapAll", i), 64'(fofbBitmapAll), 64'(tbl[i].all));
      chk($sformatf("tbl%0d.bitmapEnabled", i), 64'(fofbBitmapEnabled), 64'(tbl[i].ena));
      chk($sformatf("tbl%0d.seqno", i), 64'(seqno), 64'(tbl[i].seq));
      if (tbl[i].fe >= 0) chk($sformatf("tbl%0d.fofbEnabled", i), 64'(fofbEnabled), 64'(tbl[i].fe));
    end
    FAstrobe = 0;
    // Duplicate cell 7 from both links, within a cycle and across cycles
    cellCount = 10;
    FAstrobe = 1;
    setLinks(2'b00, 0, 0, 2'b00);
    cyc();
    FAstrobe = 0;
    setLinks(2'b11, 7, 7, 2'b00);
    cyc();
    setLinks(2'b00, 0, 0, 2'b00);
    cyc();
    setLinks(2'b11, 7, 7, 2'b11);
    cyc();
    setLinks(2'b00, 0, 0, 2'b00);
    cyc();
    chk("dup.cellCounter", 64'(cellCounter), 1);
    chk("dup.bitmapAll", 64'(fofbBitmapAll), 64'h80);
    chk("dup.bitmapEnabled", 64'(fofbBitmapEnabled), 64'h80);
    // FA while still active: overrun, then the same readout runs into a 3 us timeout
    cellCount = 5;
    timeoutUs = 3;
    FAstrobe = 1;
    cyc();
    chk("ovr.strobe", 64'(overrunStrobe), 1);
    chk("ovr.snapAll", 64'(bitmapAllSnap), 64'h80);
    chk("ovr.seqno", 64'(seqno), 2);
    chk("ovr.bitmapAll", 64'(fofbBitmapAll), 0);
    FAstrobe = 0;
    setLinks(2'b11, 1, 2, 2'b11);
    cyc();
    chk("ovr.strobeGone", 64'(overrunStrobe), 0);
    setLinks(2'b00, 0, 0, 2'b00);
    cnt = 1;
    pulses = 0;
    while (!readTimeout && cnt < 1000) begin
      cyc();
      cnt++;
      if (timeoutStrobe) pulses++;
    end
    chk("tmo.cyclesAfterFA", 64'(cnt), 251);
    repeat (3) begin
      cyc();
      if (timeoutStrobe) pulses++;
    end
    chk("tmo.strobePulses", 64'(pulses), 1);
    chk("tmo.readTimeout", 64'(readTimeout), 1);
    chk("tmo.fofbEnabled", 64'(fofbEnabled), 0);
    chk("tmo.readoutTime", 64'(readoutTime), 3);
    chk("tmo.seqno", 64'(seqno), 2);
    // Randomized traffic; the model checks every cycle
    for (int c = 0; c < 4000; c++) begin
      FAstrobe = $urandom_range(0, 149) == 0;
      if ($urandom_range(0, 49) == 0) cellCount = 6'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) timeoutUs = TW'($urandom_range(0, 3));
      for (int k = 0; k < NL; k++) begin
        link.statusValid[k] = $urandom_range(0, 3) == 0;
        link.statusCode[2*k +: 2] = $urandom_range(0, 4) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
        link.statusCellIndex[k*IW +: IW] = $urandom_range(0, 9) == 0 ? IW'($urandom_range(0, 31)) : IW'($urandom_range(0, 7));
        link.statusFOFBenabled[k] = $urandom_range(0, 3) != 0;
      end
      cyc();
    end
    FAstrobe = 0;
    setLinks(2'b00, 0, 0, 2'b00);
`ifdef CELL_MISS_STATS_EN
    missAddr = 3;
    cellCount = 4;
    timeoutUs = 0;
    repeat (300) begin
      FAstrobe = 1;
      cyc();
      FAstrobe = 0;
      setLinks(2'b11, 0, 1, 2'b00);
      cyc();
      setLinks(2'b01, 2, 0, 2'b00);
      cyc();
      setLinks(2'b00, 0, 0, 2'b00);
      cyc();
    end
    chk("miss.cell3Saturated", 64'(missCount), 255);
    missAddr = 0;
    cyc();
    cyc();
    chk("miss.cell0", 64'(missCount), 0);
`endif
    // Asynchronous reset in the middle of a readout
    cellCount = 6;
    FAstrobe = 1;
    cyc();
    FAstrobe = 0;
    setLinks(2'b01, 4, 0, 2'b01);
    cyc();
    setLinks(2'b00, 0, 0, 2'b00);
    sysResetN = 0;
    #1;
    chk("rst.active", 64'(readoutActive), 0);
    chk("rst.bitmapAll", 64'(fofbBitmapAll), 0);
    chk("rst.cellCounter", 64'(cellCounter), 0);
    chk("rst.seqno", 64'(seqno), 0);
    cyc();
    sysResetN = 1;
    cyc();
    chk("rst.stillIdle", 64'(readoutActive | readoutValid | readTimeout), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
